// File: rtl/wishbone_timed_splitter.sv
// Wishbone 1-to-N splitter: decodes a slave-select field from the address, forwards one
// transfer at a time and returns a registered ack/err, with a per-transfer response timeout.
module wishbone_timed_splitter #(
   parameter int NUM_PERIPHERALS  = 10,
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int SEL_WIDTH        = DATA_WIDTH / 8,
   parameter int ADDR_SEL_LOW_BIT = 16,
   parameter int TIMEOUT_CYCLES   = 255
) (
   input  logic                                  wb_clk_i,
   input  logic                                  wb_rst_i,
   input  logic [ADDR_WIDTH-1:0]                 m_wb_adr_i,
   input  logic [DATA_WIDTH-1:0]                 m_wb_dat_i,
   input  logic                                  m_wb_we_i,
   input  logic [SEL_WIDTH-1:0]                  m_wb_sel_i,
   input  logic                                  m_wb_cyc_i,
   input  logic                                  m_wb_stb_i,
   output logic [DATA_WIDTH-1:0]                 m_wb_dat_o,
   output logic                                  m_wb_ack_o,
   output logic                                  m_wb_err_o,
   output logic [NUM_PERIPHERALS-1:0]            s_wb_cyc_o,
   output logic [NUM_PERIPHERALS-1:0]            s_wb_stb_o,
   output logic [NUM_PERIPHERALS-1:0]            s_wb_we_o,
   output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]  s_wb_sel_o,
   output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] s_wb_adr_o,
   output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_o,
   input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_i,
   input  logic [NUM_PERIPHERALS-1:0]            s_wb_ack_i,
   input  logic [NUM_PERIPHERALS-1:0]            s_wb_err_i,
   output logic                                  timeout_o,
   output logic [7:0]                            timeout_cnt_o
);

   localparam int SEL_BITS = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic                  we_q;
   logic [SEL_WIDTH-1:0]  sel_q;
   logic [SEL_BITS-1:0]   slave_q;
   logic [31:0]           wait_cnt;

   logic [SEL_BITS-1:0]   field;
   logic                  field_valid;
   logic [DATA_WIDTH-1:0] slave_dat [NUM_PERIPHERALS];
   logic                  sel_ack;
   logic                  sel_err;
   logic                  timeout_hit;

   logic                  accept;
   logic                  load_dat;
   logic                  ack_set;
   logic                  err_set;
   logic                  tmo_set;
   logic                  cnt_clr;
   logic                  cnt_inc;

   assign field       = m_wb_adr_i[ADDR_SEL_LOW_BIT +: SEL_BITS];
   assign field_valid = (32'(field) < 32'(NUM_PERIPHERALS));
   assign sel_ack     = s_wb_ack_i[slave_q];
   assign sel_err     = s_wb_err_i[slave_q];
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Only the latched slave sees cyc/stb, and only while the transfer is in flight
   for (genvar g = 0; g < NUM_PERIPHERALS; g++) begin : g_slave
      assign slave_dat[g]  = s_wb_dat_i[g*DATA_WIDTH +: DATA_WIDTH];
      assign s_wb_cyc_o[g] = (state == ACTIVE) && (slave_q == SEL_BITS'(g));
      assign s_wb_stb_o[g] = (state == ACTIVE) && (slave_q == SEL_BITS'(g));
   end

   assign s_wb_adr_o = {NUM_PERIPHERALS{adr_q}};
   assign s_wb_dat_o = {NUM_PERIPHERALS{dat_q}};
   assign s_wb_sel_o = {NUM_PERIPHERALS{sel_q}};
   assign s_wb_we_o  = {NUM_PERIPHERALS{we_q}};

   // Next-state and response decisions; priority in ACTIVE is abort, err, ack, timeout
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      load_dat   = 1'b0;
      ack_set    = 1'b0;
      err_set    = 1'b0;
      tmo_set    = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         IDLE: begin
            if (m_wb_cyc_i && m_wb_stb_i) begin
               accept = 1'b1;
               if (field_valid) begin
                  next_state = ACTIVE;
                  cnt_clr    = 1'b1;
               end else begin
                  next_state = RESP;
                  err_set    = 1'b1;
               end
            end else begin
               next_state = IDLE;
            end
         end
         ACTIVE: begin
            if (!m_wb_cyc_i) begin
               next_state = IDLE;
            end else if (sel_err) begin
               next_state = RESP;
               err_set    = 1'b1;
            end else if (sel_ack) begin
               next_state = RESP;
               ack_set    = 1'b1;
               load_dat   = 1'b1;
            end else if (timeout_hit) begin
               next_state = RESP;
               err_set    = 1'b1;
               tmo_set    = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, latched request, wait counter and registered master-side outputs
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         adr_q         <= {ADDR_WIDTH{1'b0}};
         dat_q         <= {DATA_WIDTH{1'b0}};
         we_q          <= 1'b0;
         sel_q         <= {SEL_WIDTH{1'b0}};
         slave_q       <= {SEL_BITS{1'b0}};
         wait_cnt      <= 32'd0;
         m_wb_dat_o    <= {DATA_WIDTH{1'b0}};
         m_wb_ack_o    <= 1'b0;
         m_wb_err_o    <= 1'b0;
         timeout_o     <= 1'b0;
         timeout_cnt_o <= 8'd0;
      end else begin
         state      <= next_state;
         m_wb_ack_o <= ack_set;
         m_wb_err_o <= err_set;
         timeout_o  <= tmo_set;
         if (accept) begin
            adr_q   <= m_wb_adr_i;
            dat_q   <= m_wb_dat_i;
            we_q    <= m_wb_we_i;
            sel_q   <= m_wb_sel_i;
            slave_q <= field;
         end
         if (cnt_clr) begin
            wait_cnt <= 32'd0;
         end else if (cnt_inc) begin
            wait_cnt <= wait_cnt + 32'd1;
         end
         if (load_dat) begin
            m_wb_dat_o <= slave_dat[slave_q];
         end
         if (tmo_set && (timeout_cnt_o != 8'hFF)) begin
            timeout_cnt_o <= timeout_cnt_o + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_wishbone_timed_splitter.sv
// Directed bench for wishbone_timed_splitter (3 slaves, timeout 8): stimulus pushes expected
// master responses into a scoreboard queue, a negedge monitor pops and compares them.
module tb_wishbone_timed_splitter;

   localparam int NP = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic           clk;
   logic           rst;
   logic [AW-1:0]  m_adr;
   logic [DW-1:0]  m_dati;
   logic           m_we;
   logic [SW-1:0]  m_sel;
   logic           m_cyc;
   logic           m_stb;
   logic [DW-1:0]  m_dato;
   logic           m_ack;
   logic           m_err;
   logic [NP-1:0]  s_cyc;
   logic [NP-1:0]  s_stb;
   logic [NP-1:0]  s_we;
   logic [NP*SW-1:0] s_sel;
   logic [NP*AW-1:0] s_adr;
   logic [NP*DW-1:0] s_dato;
   logic [NP*DW-1:0] s_dati;
   logic [NP-1:0]  s_ack;
   logic [NP-1:0]  s_err;
   logic           tmo;
   logic [7:0]     tmo_cnt;

   typedef struct {
      logic        ack;
      logic        err;
      logic        tmo;
      logic [7:0]  tcnt;
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc_n  = 0;
   logic [31:0] exp_dat  = 32'd0;
   logic [7:0]  exp_tcnt = 8'd0;

   wishbone_timed_splitter #(
      .NUM_PERIPHERALS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
      .ADDR_SEL_LOW_BIT(16), .TIMEOUT_CYCLES(8)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m_wb_adr_i(m_adr), .m_wb_dat_i(m_dati), .m_wb_we_i(m_we), .m_wb_sel_i(m_sel),
      .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb),
      .m_wb_dat_o(m_dato), .m_wb_ack_o(m_ack), .m_wb_err_o(m_err),
      .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_sel_o(s_sel),
      .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dato), .s_wb_dat_i(s_dati),
      .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
      .timeout_o(tmo), .timeout_cnt_o(tmo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] adr, input logic [31:0] dat, input logic we);
      m_adr  = adr;
      m_dati = dat;
      m_we   = we;
      m_sel  = 4'hF;
      m_cyc  = 1'b1;
      m_stb  = 1'b1;
   endtask

   task automatic drop();
      m_cyc = 1'b0;
      m_stb = 1'b0;
   endtask

   task automatic expect_resp(input logic ack, input logic err, input logic t, input int lat);
      exp_t e;
      e.ack  = ack;
      e.err  = err;
      e.tmo  = t;
      e.tcnt = exp_tcnt;
      e.dat  = exp_dat;
      e.cyc  = cyc_n + lat;
      sb.push_back(e);
   endtask

   // Monitor: every master response must match the oldest expected one
   always @(negedge clk) begin
      if (!rst && (m_ack || m_err || tmo)) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", {29'd0, m_ack, m_err, tmo}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_ack", {31'd0, m_ack}, {31'd0, e.ack});
            check("resp_err", {31'd0, m_err}, {31'd0, e.err});
            check("resp_timeout", {31'd0, tmo}, {31'd0, e.tmo});
            check("resp_timeout_cnt", {24'd0, tmo_cnt}, {24'd0, e.tcnt});
            check("resp_dat", m_dato, e.dat);
            check("resp_cycle", cyc_n, e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      m_adr = 32'd0; m_dati = 32'd0; m_we = 1'b0; m_sel = 4'h0;
      m_cyc = 1'b0;  m_stb  = 1'b0;
      s_dati = '0;   s_ack  = 3'b000; s_err = 3'b000;
      tick(); tick();
      check("rst_m_ack", {31'd0, m_ack}, 32'd0);
      check("rst_m_err", {31'd0, m_err}, 32'd0);
      check("rst_m_dat", m_dato, 32'd0);
      check("rst_stb", {29'd0, s_stb}, 32'd0);
      check("rst_cyc", {29'd0, s_cyc}, 32'd0);
      check("rst_tmo_cnt", {24'd0, tmo_cnt}, 32'd0);
      rst = 1'b0;

      // Read from slave 1, with noise from unselected slaves first
      start(32'h0001_0004, 32'd0, 1'b0);
      tick();
      check("rd_stb", {29'd0, s_stb}, 32'd2);
      check("rd_cyc", {29'd0, s_cyc}, 32'd2);
      check("rd_adr", s_adr[63:32], 32'h0001_0004);
      check("rd_we", {29'd0, s_we}, 32'd0);
      s_ack = 3'b001; s_err = 3'b100;
      tick();
      s_ack = 3'b000; s_err = 3'b000;
      check("rd_ignore_unsel", {29'd0, s_stb}, 32'd2);
      tick();
      s_ack = 3'b010; s_dati[63:32] = 32'hA5A5_0001;
      exp_dat = 32'hA5A5_0001;
      expect_resp(1'b1, 1'b0, 1'b0, 1);
      tick();
      s_ack = 3'b000; drop();
      tick();
      check("rd_ack_single", {31'd0, m_ack}, 32'd0);
      check("rd_dat_hold", m_dato, 32'hA5A5_0001);

      // Write to nonexistent slave 3
      start(32'h0003_0000, 32'h1111_2222, 1'b1);
      expect_resp(1'b0, 1'b1, 1'b0, 1);
      tick();
      check("bad_stb", {29'd0, s_stb}, 32'd0);
      drop();
      tick();
      check("bad_stb_after", {29'd0, s_stb}, 32'd0);
      check("bad_err_single", {31'd0, m_err}, 32'd0);

      // Slave 2 silent: eight ACTIVE cycles then timeout
      start(32'h0002_0000, 32'd0, 1'b0);
      tick();
      check("to_stb_c1", {29'd0, s_stb}, 32'd4);
      for (int i = 2; i <= 8; i++) begin
         tick();
         check("to_stb_hold", {29'd0, s_stb}, 32'd4);
      end
      exp_tcnt = 8'd1;
      expect_resp(1'b0, 1'b1, 1'b1, 1);
      tick();
      check("to_stb_drop", {29'd0, s_stb}, 32'd0);
      drop();
      tick();

      // Slave 0 returns ack and err together: err wins, data held
      start(32'h0000_0010, 32'd0, 1'b0);
      tick();
      check("ae_stb", {29'd0, s_stb}, 32'd1);
      s_ack = 3'b001; s_err = 3'b001; s_dati[31:0] = 32'hDEAD_BEEF;
      expect_resp(1'b0, 1'b1, 1'b0, 1);
      tick();
      s_ack = 3'b000; s_err = 3'b000; drop();
      tick();

      // Abort with a same-cycle slave ack
      start(32'h0001_0000, 32'd0, 1'b0);
      tick();
      check("ab_stb", {29'd0, s_stb}, 32'd2);
      drop();
      s_ack = 3'b010; s_dati[63:32] = 32'h7777_7777;
      tick();
      s_ack = 3'b000;
      check("ab_cyc", {29'd0, s_cyc}, 32'd0);
      check("ab_stb_off", {29'd0, s_stb}, 32'd0);
      check("ab_no_resp", {29'd0, m_ack, m_err, tmo}, 32'd0);
      tick();
      check("ab_dat_hold", m_dato, 32'hA5A5_0001);

      // Invalid then valid with stb held through RESP
      start(32'h0003_0004, 32'd0, 1'b0);
      expect_resp(1'b0, 1'b1, 1'b0, 1);
      tick();
      m_adr = 32'h0001_0008;
      tick();
      check("b2b_resp_ignores_stb", {29'd0, s_stb}, 32'd0);
      tick();
      check("b2b_stb", {29'd0, s_stb}, 32'd2);
      check("b2b_adr", s_adr[63:32], 32'h0001_0008);
      s_ack = 3'b010; s_dati[63:32] = 32'h5555_AAAA;
      exp_dat = 32'h5555_AAAA;
      expect_resp(1'b1, 1'b0, 1'b0, 1);
      tick();
      s_ack = 3'b000; drop();
      tick();

      // Reset pulse mid-ACTIVE, then a normal transfer
      start(32'h0002_0008, 32'd0, 1'b0);
      tick();
      check("rm_stb", {29'd0, s_stb}, 32'd4);
      #2 rst = 1'b1;
      #1;
      check("rm_stb_zero", {29'd0, s_stb}, 32'd0);
      check("rm_cyc_zero", {29'd0, s_cyc}, 32'd0);
      check("rm_adr_zero", s_adr[95:64], 32'd0);
      check("rm_dat_zero", m_dato, 32'd0);
      check("rm_tmo_cnt_zero", {24'd0, tmo_cnt}, 32'd0);
      exp_dat  = 32'd0;
      exp_tcnt = 8'd0;
      start(32'h0000_0000, 32'd0, 1'b0);
      rst = 1'b0;
      tick();
      check("rr_stb", {29'd0, s_stb}, 32'd1);
      s_ack = 3'b001; s_dati[31:0] = 32'h1234_5678;
      exp_dat = 32'h1234_5678;
      expect_resp(1'b1, 1'b0, 1'b0, 1);
      tick();
      s_ack = 3'b000; drop();
      tick();
      tick();

      check("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wishbone_timed_splitter.md
WISHBONE_TIMED_SPLITTER -- requirements
Module: wishbone_timed_splitter

Interface
REQ-001 SHALL take parameters (name, default, meaning), one per line:
- NUM_PERIPHERALS, 10, number of slave ports (>=1)
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width
- SEL_WIDTH, DATA_WIDTH/8, byte-select width
- ADDR_SEL_LOW_BIT, 16, lowest address bit of the slave-select field
- TIMEOUT_CYCLES, 255, cycles allowed for a slave response; 0 disables the timeout
REQ-002 SHALL have the following ports (name direction width meaning), one per line:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- m_wb_adr_i/dat_i/we_i/sel_i/cyc_i/stb_i  in  ADDR_WIDTH/DATA_WIDTH/1/SEL_WIDTH/1/1  master request
- m_wb_dat_o  out  DATA_WIDTH  read data, registered
- m_wb_ack_o, m_wb_err_o  out  1 each  master response, registered
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  NUM_PERIPHERALS each  per-slave control
- s_wb_sel_o, s_wb_adr_o, s_wb_dat_o  out  NUM_PERIPHERALS x SEL/ADDR/DATA_WIDTH  per-slave request, packed with slave g at slice g
- s_wb_dat_i  in  NUM_PERIPHERALS*DATA_WIDTH  slave read data, packed
- s_wb_ack_i, s_wb_err_i  in  NUM_PERIPHERALS each  slave responses
- timeout_o  out  1  one-cycle pulse on each timeout
- timeout_cnt_o  out  8  count of timeouts, saturating at 255

Function
REQ-003 Select field SHALL be adr[ADDR_SEL_LOW_BIT +: W], W = max(1, clog2(NUM_PERIPHERALS)); the address is valid iff field < NUM_PERIPHERALS.
REQ-004 SHALL implement an FSM with states IDLE, ACTIVE and RESP.
REQ-005 IDLE: when cyc_i&stb_i, SHALL latch adr, dat, we, sel and the select field into registers; valid -> ACTIVE, invalid -> RESP with err pending.
REQ-006 ACTIVE: SHALL drive s_wb_cyc_o[sel_q] and s_wb_stb_o[sel_q] high and all other bits low.
REQ-007 ACTIVE: s_wb_adr/dat/we/sel_o SHALL carry the latched values, broadcast to all slices.
REQ-008 Outside ACTIVE, all s_wb_cyc_o and s_wb_stb_o bits SHALL be 0.
REQ-009 ACTIVE, s_wb_ack_i[sel_q]=1: SHALL register m_wb_dat_o from slice sel_q, set ack, go to RESP.
REQ-010 ACTIVE, s_wb_err_i[sel_q]=1: SHALL set err and go to RESP; err SHALL win when ack and err arrive together.
REQ-011 Responses from unselected slaves SHALL be ignored.
REQ-012 Timeout counter SHALL clear on entry to ACTIVE and increment on each ACTIVE cycle with no response. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no response, it SHALL set err, pulse timeout_o, increment timeout_cnt_o and go to RESP.
REQ-013 A slave response in the terminal timeout cycle SHALL win over the timeout.
REQ-014 ACTIVE with cyc_i=0 (abort) SHALL go to IDLE with no ack, no err and no timeout; abort SHALL win over a same-cycle slave response.
REQ-015 RESP: m_wb_ack_o or m_wb_err_o SHALL be high for exactly this one cycle, never both; next state SHALL be IDLE; stb_i SHALL be ignored in RESP.
REQ-016 Latency: slave request SHALL appear 1 cycle after acceptance; master ack/err SHALL appear 1 cycle after the slave response; invalid-address err SHALL appear 1 cycle after acceptance.
REQ-017 m_wb_dat_o SHALL hold its last value except on a forwarded ack.
REQ-018 Back-to-back operation: a new transfer SHALL be accepted in the IDLE cycle that follows RESP.

Reset
REQ-019 wb_rst_i SHALL asynchronously force state=IDLE and all outputs, counters and latched registers to 0, including mid-transfer.
REQ-020 The first transfer after reset release SHALL be accepted on the first rising edge with cyc&stb.

Verification (NUM_PERIPHERALS=3, ADDR_SEL_LOW_BIT=16, TIMEOUT_CYCLES=8)
REQ-021 The bench SHALL cover the following directed scenarios:
- Read adr 0x0001_0004; slave 1 acks 2 cycles after s_stb with 0xA5A5_0001 -> s_stb_o=3'b010; m_ack 1 cycle after slave ack, single pulse, m_dat=0xA5A5_0001.
- Write adr 0x0003_0000 -> no s_stb bit ever high; m_err high 1 cycle, 1 cycle after acceptance.
- Slave 2 never responds -> m_err and timeout_o at ACTIVE cycle 8; s_stb_o[2] low next cycle; timeout_cnt_o=1.
- Slave 0 asserts ack and err in the same cycle -> m_err=1, m_ack=0.
- Master drops cyc in ACTIVE -> s_cyc_o=s_stb_o=0 next cycle; no ack, no err, no timeout.
- wb_rst_i pulsed mid-ACTIVE -> all outputs 0 immediately; the next transfer completes normally.
